ecall_io_sequencer: RTL

Sequences ecall environment calls for the single-cycle core. It stalls instruction fetch while a service is pending and debounces the confirm button. It captures switch or test-number input into a0 through a one-cycle register write, and drives the segment-display value and status LEDs. It sits between the controller's ecall decode, the register file's a0 and a7 values, the fetch stall input, and the board I/O.

---
 rtl/ecall_io_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ecall_io_sequencer.sv
// ecall I/O sequencer: stalls fetch while an environment call is serviced,
// debounces the confirm button and writes switch input back into a0.
module ecall_io_sequencer #(
    parameter int DEBOUNCE_CYCLES = 230000,
    parameter int CNT_W           = 18
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ecall,
    input  logic [31:0] a7_data,
    input  logic [31:0] a0_data,
    input  logic        confirm_button,
    input  logic [15:0] imm_input,
    input  logic [2:0]  test_number,
    output logic        stall,
    output logic        wb_en,
    output logic [31:0] wb_data,
    output logic [31:0] seg_value,
    output logic        seg_en,
    output logic [7:0]  led_output,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_PRESS, S_WAIT_RELEASE,
        S_COMMIT, S_RELEASE, S_HALT
    } state_t;

    typedef enum logic [1:0] {
        C_PRINT, C_READ_INT, C_READ_CASE, C_EXIT
    } code_t;

    state_t     r_state;
    state_t     w_state_next;
    code_t      r_code;
    code_t      w_code_in;
    code_t      w_code_next;
    logic       w_supported;
    logic       w_accept;

    logic       r_sync1;
    logic       r_sync2;
    logic       r_deb;
    logic       r_deb_q;
    logic [CNT_W-1:0] r_cnt;
    logic       w_press;
    logic       w_release;

    logic [31:0] r_seg_value;
    logic        r_seg_en;
    logic [7:0]  r_led;
    logic        w_wait_next;

    // Synchronize, debounce and delay the button level for edge detection
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_deb   <= 1'b0;
            r_deb_q <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= confirm_button;
            r_sync2 <= r_sync1;
            r_deb_q <= r_deb;
            if (r_sync2 == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_deb <= ~r_deb;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign w_press   = r_deb & ~r_deb_q;
    assign w_release = ~r_deb & r_deb_q;

    // Decode the service code with a full-width compare
    always_comb begin
        w_supported = 1'b1;
        w_code_in   = C_PRINT;
        unique case (1'b1)
            (a7_data == 32'd1):  w_code_in = C_PRINT;
            (a7_data == 32'd5):  w_code_in = C_READ_INT;
            (a7_data == 32'd12): w_code_in = C_READ_CASE;
            (a7_data == 32'd10): w_code_in = C_EXIT;
            default:             w_supported = 1'b0;
        endcase
    end

    assign w_accept    = (r_state == S_IDLE) && ecall && w_supported;
    assign w_code_next = w_accept ? w_code_in : r_code;

    // State, latched service code, display and LED registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_code      <= C_PRINT;
            r_seg_value <= 32'h0;
            r_seg_en    <= 1'b0;
            r_led       <= 8'h0;
        end else begin
            r_state <= w_state_next;
            r_code  <= w_code_next;
            if (w_accept && (w_code_in == C_PRINT)) begin
                r_seg_value <= a0_data;
                r_seg_en    <= 1'b1;
            end
            r_led <= {w_wait_next && (w_code_next == C_READ_INT),
                      5'b0,
                      w_wait_next && (w_code_next == C_READ_CASE),
                      w_state_next == S_HALT};
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = (w_code_in == C_EXIT) ? S_HALT
                                                         : S_WAIT_PRESS;
                end
            end
            S_WAIT_PRESS:   if (w_press)   w_state_next = S_WAIT_RELEASE;
            S_WAIT_RELEASE: if (w_release) w_state_next = S_COMMIT;
            S_COMMIT:       w_state_next = S_RELEASE;
            S_RELEASE:      w_state_next = S_IDLE;
            S_HALT:         w_state_next = S_HALT;
            default:        w_state_next = S_IDLE;
        endcase
    end

    assign w_wait_next = (w_state_next == S_WAIT_PRESS) ||
                         (w_state_next == S_WAIT_RELEASE);

    // Outputs decoded from the current state
    always_comb begin
        stall   = 1'b0;
        wb_en   = 1'b0;
        wb_data = 32'h0;
        halted  = 1'b0;
        case (r_state)
            S_IDLE:         stall = w_accept;
            S_WAIT_PRESS:   stall = 1'b1;
            S_WAIT_RELEASE: stall = 1'b1;
            S_COMMIT: begin
                stall = 1'b1;
                if (r_code == C_READ_INT) begin
                    wb_en   = 1'b1;
                    wb_data = {16'h0, imm_input};
                end else if (r_code == C_READ_CASE) begin
                    wb_en   = 1'b1;
                    wb_data = {29'h0, test_number};
                end
            end
            S_RELEASE:      stall = 1'b0;
            S_HALT: begin
                stall  = 1'b1;
                halted = 1'b1;
            end
            default:        stall = 1'b0;
        endcase
    end

    assign seg_value  = r_seg_value;
    assign seg_en     = r_seg_en;
    assign led_output = r_led;

endmodule
